// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the serial ADC frame sequencer.
// Build option: ADC_FRAME_CONT_EN (see adc_frame_ctrl).
package adc_frame_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Opcodes understood by bit_cnt
    localparam logic [1:0] CNT_HOLD = 2'b00;
    localparam logic [1:0] CNT_INC  = 2'b01;
    localparam logic [1:0] CNT_CLR  = 2'b10;

endpackage

// File: rtl/adc_frame_ctrl_bit_cnt.sv
// Up-counter with hold/increment/clear opcode, used to count dclk rises.
module bit_cnt
    import adc_frame_pkg::*;
#(
    parameter int Width = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       op,
    output logic [Width-1:0] count
);

    // Apply the opcode; the reserved code 2'b11 behaves as hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {Width{1'b0}};
        end else begin
            case (op)
                CNT_INC:  count <= count + {{(Width-1){1'b0}}, 1'b1};
                CNT_CLR:  count <= {Width{1'b0}};
                CNT_HOLD: count <= count;
                default:  count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_frame_ctrl.sv
// Serial ADC read-frame sequencer: chip select, dclk generation, MSB-first
// capture of NBits serial bits and a one-cycle valid pulse per frame.
// Build option: define ADC_FRAME_CONT_EN to add cont_i (free-running frames).
module adc_frame_ctrl
    import adc_frame_pkg::*;
#(
    parameter int NBits    = 25,
    parameter int HalfDiv  = 2,
    parameter int SetupCyc = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             sdata_i,
`ifdef ADC_FRAME_CONT_EN
    input  logic             cont_i,
`endif
    output logic             cs_n_o,
    output logic             dclk_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [NBits-1:0] data_o
);

    localparam int CntW = $clog2(NBits + 1);
    localparam int DivW = (HalfDiv > 1) ? $clog2(HalfDiv) : 1;
    localparam int SetW = (SetupCyc > 1) ? $clog2(SetupCyc) : 1;

    localparam logic [CntW-1:0] BitsLast  = CntW'(NBits);
    localparam logic [DivW-1:0] DivLast   = DivW'(HalfDiv - 1);
    localparam logic [SetW-1:0] SetupLast = SetW'(SetupCyc - 1);

    state_t             state_r, state_s;
    logic [DivW-1:0]    div_r, div_s;
    logic [SetW-1:0]    setup_r, setup_s;
    logic               dclk_r, dclk_s;
    logic [NBits-1:0]   shift_r, shift_s;
    logic [1:0]         cnt_op_s;
    logic [CntW-1:0]    bit_count_s;
    logic               restart_s;
    logic               cs_n_r, busy_r, valid_r;
    logic [NBits-1:0]   data_r;

    // DONE re-enters SETUP on start, or on cont_i when continuous mode is built in
`ifdef ADC_FRAME_CONT_EN
    assign restart_s = start_i | cont_i;
`else
    assign restart_s = start_i;
`endif

    bit_cnt #(.Width(CntW)) u_bit_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .op    (cnt_op_s),
        .count (bit_count_s)
    );

    // Next-state logic for the sequencer, divider, setup timer and shifter
    always_comb begin
        state_s  = state_r;
        div_s    = div_r;
        setup_s  = setup_r;
        dclk_s   = dclk_r;
        shift_s  = shift_r;
        cnt_op_s = CNT_HOLD;
        if (abort_i) begin
            state_s  = IDLE;
            div_s    = {DivW{1'b0}};
            setup_s  = {SetW{1'b0}};
            dclk_s   = 1'b0;
            cnt_op_s = CNT_CLR;
        end else begin
            case (state_r)
                IDLE: begin
                    div_s   = {DivW{1'b0}};
                    setup_s = {SetW{1'b0}};
                    dclk_s  = 1'b0;
                    if (start_i) begin
                        state_s = SETUP;
                    end else begin
                        state_s = IDLE;
                    end
                end
                SETUP: begin
                    if (setup_r == SetupLast) begin
                        state_s = SHIFT;
                        setup_s = {SetW{1'b0}};
                        div_s   = {DivW{1'b0}};
                    end else begin
                        setup_s = setup_r + {{(SetW-1){1'b0}}, 1'b1};
                    end
                end
                SHIFT: begin
                    if (div_r == DivLast) begin
                        div_s = {DivW{1'b0}};
                        if (!dclk_r) begin
                            // Rising dclk edge: capture the bit and count it
                            dclk_s   = 1'b1;
                            shift_s  = {shift_r[NBits-2:0], sdata_i};
                            cnt_op_s = CNT_INC;
                        end else if (bit_count_s == BitsLast) begin
                            dclk_s  = 1'b0;
                            state_s = DONE;
                        end else begin
                            dclk_s = 1'b0;
                        end
                    end else begin
                        div_s = div_r + {{(DivW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    cnt_op_s = CNT_CLR;
                    if (restart_s) begin
                        state_s = SETUP;
                    end else begin
                        state_s = IDLE;
                    end
                end
                default: begin
                    state_s  = IDLE;
                    cnt_op_s = CNT_CLR;
                end
            endcase
        end
    end

    // Sequencer state, counters and shifter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            div_r   <= {DivW{1'b0}};
            setup_r <= {SetW{1'b0}};
            dclk_r  <= 1'b0;
            shift_r <= {NBits{1'b0}};
        end else begin
            state_r <= state_s;
            div_r   <= div_s;
            setup_r <= setup_s;
            dclk_r  <= dclk_s;
            shift_r <= shift_s;
        end
    end

    // Registered outputs decoded from the next state so they align with it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cs_n_r  <= 1'b1;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            data_r  <= {NBits{1'b0}};
        end else begin
            cs_n_r  <= !((state_s == SETUP) || (state_s == SHIFT));
            busy_r  <= (state_s == SETUP) || (state_s == SHIFT);
            valid_r <= (state_s == DONE);
            if (state_s == DONE) begin
                data_r <= shift_r;
            end
        end
    end

    assign cs_n_o  = cs_n_r;
    assign dclk_o  = dclk_r;
    assign busy_o  = busy_r;
    assign valid_o = valid_r;
    assign data_o  = data_r;

endmodule
